// File: rtl/aes_input_dispatch.sv
// aes_input_dispatch: pops entries from the input buffer FIFO, decodes the tag
// and routes the payload to the key register or to the AES core.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  IDLE    | nothing in progress; pop when the buffer is non-empty
//  FETCH   | popped entry is on fifo_dout; decode tag and latch payload
//  SEND    | block offered to the core, held until blk_ready
//  KEYWAIT | key entry captured; waiting for the core to go idle
module aes_input_dispatch #(
    parameter int DATA_W = 128,
    parameter int TAG_W  = 3,
    parameter int CNT_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    fifo_empty,
    output logic                    fifo_rd_en,
    input  logic [DATA_W+TAG_W-1:0] fifo_dout,
    input  logic                    core_idle,
    output logic [DATA_W-1:0]       key_out,
    output logic                    key_valid,
    output logic                    key_load,
    output logic                    blk_valid,
    input  logic                    blk_ready,
    output logic [DATA_W-1:0]       blk_data,
    output logic                    blk_decrypt,
    output logic                    err_illegal,
    output logic [CNT_W-1:0]        drop_cnt
);

    localparam logic [TAG_W-1:0] TAG_KEY = TAG_W'(1);
    localparam logic [TAG_W-1:0] TAG_ENC = TAG_W'(2);
    localparam logic [TAG_W-1:0] TAG_DEC = TAG_W'(3);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        SEND    = 2'd2,
        KEYWAIT = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [TAG_W-1:0]  tag_in;
    logic [DATA_W-1:0] payload_in;
    logic [DATA_W-1:0] key_hold;
    logic              is_blk;
    logic              is_key;
    logic              is_illegal;

    assign tag_in     = fifo_dout[DATA_W+TAG_W-1:DATA_W];
    assign payload_in = fifo_dout[DATA_W-1:0];
    assign is_blk     = (tag_in == TAG_ENC) || (tag_in == TAG_DEC);
    assign is_key     = (tag_in == TAG_KEY);
    assign is_illegal = (tag_in > TAG_DEC);

    // The offered block lives exactly as long as the SEND state, so it drops
    // together with the async state reset.
    assign blk_valid = (state == SEND);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and pop strobe; a pop is only issued from IDLE or on
    // the SEND handshake cycle, so at most one read is ever outstanding.
    always_comb begin
        state_nxt  = state;
        fifo_rd_en = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_rd_en = 1'b1;
                    state_nxt  = FETCH;
                end
            end
            FETCH: begin
                if (is_key) begin
                    state_nxt = KEYWAIT;
                end else if (is_blk && key_valid) begin
                    state_nxt = SEND;
                end else begin
                    state_nxt = IDLE;
                end
            end
            SEND: begin
                if (blk_ready) begin
                    if (!fifo_empty) begin
                        fifo_rd_en = 1'b1;
                        state_nxt  = FETCH;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            KEYWAIT: begin
                if (core_idle) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (rst) begin
            fifo_rd_en = 1'b0;
        end
    end

    // Datapath: payload capture, key update, error pulse and drop counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_hold    <= '0;
            key_out     <= '0;
            key_valid   <= 1'b0;
            key_load    <= 1'b0;
            blk_data    <= '0;
            blk_decrypt <= 1'b0;
            err_illegal <= 1'b0;
            drop_cnt    <= '0;
        end else begin
            key_load    <= 1'b0;
            err_illegal <= 1'b0;
            if (state == FETCH) begin
                key_hold <= payload_in;
                if (is_illegal) begin
                    err_illegal <= 1'b1;
                end
                if (is_blk && key_valid) begin
                    blk_data    <= payload_in;
                    blk_decrypt <= (tag_in == TAG_DEC);
                end
                if (is_blk && !key_valid && (drop_cnt != '1)) begin
                    drop_cnt <= drop_cnt + CNT_W'(1);
                end
            end
            if ((state == KEYWAIT) && core_idle) begin
                key_out   <= key_hold;
                key_valid <= 1'b1;
                key_load  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_aes_input_dispatch.sv
// Testbench for aes_input_dispatch: queue-based FIFO model and a
// transaction-level scoreboard of expected blocks, keys, errors and drops.
module tb_aes_input_dispatch;

    localparam int DATA_W = 128;
    localparam int TAG_W  = 3;
    localparam int CNT_W  = 8;

    localparam logic [127:0] KEY0 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] ENC0 = 128'h00112233445566778899aabbccddeeff;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    fifo_empty;
    logic                    fifo_rd_en;
    logic [DATA_W+TAG_W-1:0] fifo_dout;
    logic                    core_idle;
    logic [DATA_W-1:0]       key_out;
    logic                    key_valid;
    logic                    key_load;
    logic                    blk_valid;
    logic                    blk_ready;
    logic [DATA_W-1:0]       blk_data;
    logic                    blk_decrypt;
    logic                    err_illegal;
    logic [CNT_W-1:0]        drop_cnt;

    always #5 clk = ~clk;

    aes_input_dispatch #(.DATA_W(DATA_W), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .fifo_dout  (fifo_dout),
        .core_idle  (core_idle),
        .key_out    (key_out),
        .key_valid  (key_valid),
        .key_load   (key_load),
        .blk_valid  (blk_valid),
        .blk_ready  (blk_ready),
        .blk_data   (blk_data),
        .blk_decrypt(blk_decrypt),
        .err_illegal(err_illegal),
        .drop_cnt   (drop_cnt)
    );

    // FIFO contents and expected outcomes ({decrypt, data} per block)
    logic [130:0] q[$];
    logic [128:0] exp_blk[$];
    logic [127:0] exp_key[$];
    bit           m_kv;
    int           m_drop;
    int           exp_err;

    int n_cmp = 0;
    int n_err = 0;
    int act_err, act_kl, rd_total, cyc, n_hs;
    int hs_cyc[$];

    logic         s_rd, s_valid, s_dec, s_kl, s_err, s_kv;
    logic [127:0] s_data, s_key;
    logic         prev_stall, prev_dec;
    logic [127:0] prev_data;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Enqueue an entry and derive its outcome from the tag rules in FIFO order.
    task automatic push(input logic [2:0] tag, input logic [127:0] data);
        q.push_back({tag, data});
        fifo_empty = 1'b0;
        case (tag)
            3'd0: ;
            3'd1: begin
                exp_key.push_back(data);
                m_kv = 1'b1;
            end
            3'd2, 3'd3: begin
                if (m_kv) exp_blk.push_back({tag[0], data});
                else if (m_drop < 255) m_drop++;
            end
            default: exp_err++;
        endcase
    endtask

    // One clock: sample at negedge, score, then service the FIFO after posedge.
    task automatic cycle();
        logic [128:0] front;
        logic [127:0] k;
        @(negedge clk);
        s_rd    = fifo_rd_en;
        s_valid = blk_valid;
        s_data  = blk_data;
        s_dec   = blk_decrypt;
        s_kl    = key_load;
        s_err   = err_illegal;
        s_kv    = key_valid;
        s_key   = key_out;
        cyc++;
        if (s_rd) begin
            rd_total++;
            chk("rd_while_empty", fifo_empty, 0);
        end
        if (s_err || s_kl) chk("err_with_keyload", s_err & s_kl, 0);
        if (prev_stall) begin
            chk("stall_valid", s_valid, 1);
            chk("stall_data", s_data, prev_data);
            chk("stall_dec", s_dec, prev_dec);
        end
        if (s_valid && blk_ready) begin
            n_hs++;
            hs_cyc.push_back(cyc);
            if (exp_blk.size() == 0) begin
                chk("blk_unexpected", s_valid, 0);
            end else begin
                front = exp_blk.pop_front();
                chk("blk_data", s_data, front[127:0]);
                chk("blk_dec", s_dec, front[128]);
            end
        end
        prev_stall = s_valid && !blk_ready;
        prev_data  = s_data;
        prev_dec   = s_dec;
        if (s_err) act_err++;
        if (s_kl) begin
            act_kl++;
            if (exp_key.size() == 0) begin
                chk("keyload_unexpected", s_kl, 0);
            end else begin
                k = exp_key.pop_front();
                chk("key_out", s_key, k);
                chk("key_valid_on_load", s_kv, 1);
            end
        end
        @(posedge clk);
        #1;
        if (s_rd && q.size() > 0) fifo_dout = q.pop_front();
        fifo_empty = (q.size() == 0);
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        #1;
        chk("rst_blk_valid", blk_valid, 0);
        chk("rst_key_valid", key_valid, 0);
        chk("rst_key_out", key_out, 0);
        chk("rst_key_load", key_load, 0);
        chk("rst_err", err_illegal, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        chk("rst_blk_data", blk_data, 0);
        q.delete();
        exp_blk.delete();
        exp_key.delete();
        fifo_empty = 1'b1;
        m_kv       = 1'b0;
        m_drop     = 0;
        exp_err    = 0;
        act_err    = 0;
        act_kl     = 0;
        prev_stall = 1'b0;
        repeat (2) cycle();
        chk("rst_rd_en", fifo_rd_en, 0);
        rst = 1'b0;
    endtask

    task automatic drain(input int budget);
        int i;
        i = 0;
        blk_ready = 1'b1;
        core_idle = 1'b1;
        while ((q.size() != 0 || exp_blk.size() != 0 || exp_key.size() != 0) && i < budget) begin
            cycle();
            i++;
        end
        repeat (4) cycle();
        chk("drain_fifo_left", q.size(), 0);
        chk("drain_blk_left", exp_blk.size(), 0);
        chk("drain_key_left", exp_key.size(), 0);
        chk("drop_cnt", drop_cnt, m_drop);
        chk("err_count", act_err, exp_err);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd0, hs0, r;
        logic [2:0]   tag;
        logic [127:0] d2;
        fifo_empty = 1'b1;
        fifo_dout  = '0;
        core_idle  = 1'b1;
        blk_ready  = 1'b1;
        cyc = 0; rd_total = 0; n_hs = 0;
        reset_dut();

        // key load gated by core_idle
        core_idle = 1'b0;
        rd0 = rd_total;
        push(3'd1, KEY0);
        cycle();
        chk("key_rd_en", s_rd, 1);
        repeat (6) cycle();
        chk("key_wait_no_load", act_kl, 0);
        chk("key_wait_no_valid", s_kv, 0);
        drain(20);
        chk("key_rd_once", rd_total - rd0, 1);
        chk("key_out_final", key_out, KEY0);
        chk("key_valid_final", key_valid, 1);
        chk("key_load_count", act_kl, 1);

        // single encrypt, two-cycle latency
        push(3'd2, ENC0);
        cycle();
        chk("enc_rd_en", s_rd, 1);
        cycle();
        chk("enc_valid_early", s_valid, 0);
        cycle();
        chk("enc_valid", s_valid, 1);
        chk("enc_data", s_data, ENC0);
        chk("enc_dec", s_dec, 0);
        drain(20);

        // four decrypt blocks back to back
        hs0 = hs_cyc.size();
        for (int i = 0; i < 4; i++) push(3'd3, rnd128());
        drain(40);
        chk("dec_hs_count", hs_cyc.size() - hs0, 4);
        for (int i = 1; i < 4; i++) chk("dec_spacing", hs_cyc[hs0+i] - hs_cyc[hs0+i-1], 2);

        // drops without a key, saturating counter
        reset_dut();
        hs0 = n_hs;
        push(3'd2, rnd128());
        drain(20);
        chk("drop_one", drop_cnt, 1);
        for (int i = 0; i < 299; i++) push(3'($urandom_range(2, 3)), rnd128());
        drain(1000);
        chk("drop_sat", drop_cnt, 255);
        chk("drop_no_blk", n_hs - hs0, 0);

        // illegal tag then NOP
        push(3'd6, rnd128());
        push(3'd0, rnd128());
        drain(20);
        chk("illegal_err_once", act_err, 1);
        chk("illegal_no_keyload", act_kl, 0);
        chk("illegal_no_blk", n_hs - hs0, 0);
        push(3'd2, rnd128());
        cycle();
        chk("idle_after_illegal", s_rd, 1);
        drain(20);

        // stall in SEND, then reset mid-SEND
        reset_dut();
        d2 = rnd128();
        blk_ready = 1'b0;
        core_idle = 1'b1;
        push(3'd1, rnd128());
        push(3'd2, d2);
        for (int i = 0; i < 20 && !s_valid; i++) cycle();
        chk("send_reached", s_valid, 1);
        repeat (10) cycle();
        chk("stall_data_end", s_data, d2);
        reset_dut();
        rd0 = rd_total;
        repeat (5) cycle();
        chk("no_rd_after_rst", rd_total - rd0, 0);
        push(3'd2, rnd128());
        cycle();
        chk("rd_after_push", s_rd, 1);
        drain(20);
        chk("key_gone_after_rst", key_valid, 0);

        // randomized traffic
        reset_dut();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) < 40) begin
                r = $urandom_range(0, 99);
                if (r < 10)      tag = 3'd0;
                else if (r < 20) tag = 3'd1;
                else if (r < 55) tag = 3'd2;
                else if (r < 90) tag = 3'd3;
                else             tag = 3'(4 + $urandom_range(0, 3));
                push(tag, rnd128());
            end
            blk_ready = ($urandom_range(0, 99) < 70);
            core_idle = ($urandom_range(0, 99) < 70);
            cycle();
        end
        drain(3000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
